booth_seq_ctrl: RTL and testbench
=================================

Name: booth_seq_ctrl

Overview:
- Multi-cycle radix-2 Booth multiply unit for the 16-bit CISC core's execute stage: one Booth add/sub-and-arithmetic-shift step per clock instead of a fully unrolled combinational array.
- Owns the A/Q/M iteration registers, the step counter and a valid/ready request/response handshake with the CPU controller.
- Supports signed and unsigned operands and a synchronous flush for pipeline cancel.

Parameters:
- WIDTH, 16, operand width in bits; the product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+2), step counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  operands and sgn valid.
- req_ready  out  1  unit can accept a request; high only in IDLE with rst_n high.
- req_q  in  WIDTH  multiplier Q.
- req_m  in  WIDTH  multiplicand M.
- req_sgn  in  1  1 = both operands two's-complement, 0 = both unsigned.
- flush  in  1  synchronous cancel of any in-flight or held operation.
- resp_valid  out  1  product valid.
- resp_ready  in  1  consumer accepts the product.
- resp_z  out  2*WIDTH  product.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, async): state=IDLE, A=0, Q=0, M=0, cnt=0. Outputs: resp_valid=0, resp_z=0, busy=0, req_ready=0 while rst_n is low.
- States: IDLE, RUN, DONE. Transitions on each rising clk:
  - IDLE -> RUN on req_valid & req_ready & !flush.
  - RUN -> DONE when the step with cnt==WIDTH executes.
  - DONE -> IDLE on resp_ready.
  - flush -> IDLE from any state, with priority over every other transition. Result is discarded and a same-cycle request is not accepted.
- Load at accept:
  - Qh = req_sgn ? req_q[WIDTH-1] : 0; Mh = req_sgn ? req_m[WIDTH-1] : 0.
  - A <= 0 (WIDTH+1 bits); Q <= {Qh, req_q, 1'b0} (WIDTH+2 bits); M <= {Mh, req_m} (WIDTH+1 bits); cnt <= 0.
- RUN step (one per cycle), selected on Q[1:0]:
  - 00/11: S = A. 01: S = A + M. 10: S = A - M (two's complement, mod 2^(WIDTH+1)).
  - A <= {S[WIDTH], S[WIDTH:1]}; Q <= {S[0], Q[WIDTH+1:1]}; cnt <= cnt+1.
  - Exactly WIDTH+1 steps execute (cnt 0..WIDTH).
- Result:
  - resp_z = low 2*WIDTH bits of {A, Q[WIDTH+1:1]}, driven from the registers and valid whenever resp_valid is high.
  - resp_z equals the exact signed product (req_sgn=1) or unsigned product (req_sgn=0) of the captured operands; no overflow is possible.
  - A, Q and M hold their values in DONE; resp_z is 0 outside DONE.
- Latency: the request is accepted on edge E0; resp_valid rises after edge E(WIDTH+1), i.e. WIDTH+1 cycles, and stays high until the resp_ready edge or a flush.
- Throughput: no back-to-back issue. req_ready is low in RUN and DONE, and the earliest next accept is the cycle after DONE->IDLE. Minimum period is WIDTH+3 cycles with resp_ready tied high.
- Input stability: req_q, req_m and req_sgn are sampled only on the accept edge; later changes have no effect.
- resp_ready outside DONE is ignored. req_valid outside IDLE is ignored; the requester must hold it until req_ready.
- rst_n asserted mid-RUN or mid-DONE: immediate IDLE, outputs cleared, no response ever produced for that request.

Test Plan (WIDTH=16):
1. Signed: q=0x0003, m=0xFFFB, sgn=1 -> resp_z=0xFFFFFFF1; resp_valid high exactly 17 cycles after the accept edge.
2. Unsigned: q=0xFFFF, m=0xFFFF, sgn=0 -> 0xFFFE0001. The same operands with sgn=1 -> 0x00000001.
3. Signed corner: q=0x8000, m=0x8000, sgn=1 -> 0x40000000. q=0x8000, m=0x7FFF, sgn=1 -> 0xC0008000. Any operand 0x0000 -> 0.
4. Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_z is stable and req_ready stays 0. Assert resp_ready -> IDLE next edge and req_ready=1; a new request is accepted on the following edge.
5. Flush: pulse flush at step 8, then in DONE, then in the same cycle as a req_valid in IDLE -> IDLE and resp_valid=0 in each case, and no request is accepted on the flush cycle.
6. Async reset: drop rst_n mid-RUN between clock edges -> all outputs 0 immediately. Release rst_n -> req_ready=1, and a fresh 3*7 unsigned request returns 0x00000015.

Source files
------------

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one add/sub + arithmetic shift per clock.
// Latency: WIDTH+1 cycles from the accept edge to resp_valid.
// Backpressure: the product is held in DONE until resp_ready; no new request is taken until then.
module booth_seq_ctrl #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_q,
    input  logic [WIDTH-1:0]     req_m,
    input  logic                 req_sgn,
    input  logic                 flush,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2*WIDTH-1:0]   resp_z,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH:0]     a;
    logic [WIDTH+1:0]   q;
    logic [WIDTH:0]     m;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     s_sum;
    logic               accept;
    logic               last_step;

    assign req_ready  = rst_n && (state == IDLE);
    assign accept     = (state == IDLE) && req_valid && !flush;
    assign last_step  = (cnt == CNT_W'(WIDTH));
    assign resp_valid = (state == DONE);
    assign busy       = (state == RUN) || (state == DONE);

    // The product fits in 2*WIDTH bits, so the two top bits of A are only sign copies.
    assign resp_z = (state == DONE) ? {a[WIDTH-2:0], q[WIDTH+1:1]} : '0;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (req_valid) state_nxt = RUN;
                RUN:     if (last_step) state_nxt = DONE;
                DONE:    if (resp_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        s_sum = a;
        case (q[1:0])
            2'b01:   s_sum = a + m;
            2'b10:   s_sum = a - m;
            default: s_sum = a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a   <= '0;
            q   <= '0;
            m   <= '0;
            cnt <= '0;
        end else if (accept) begin
            // Operands widened by one bit so unsigned values look positive to the Booth recoder.
            a   <= '0;
            q   <= {req_sgn & req_q[WIDTH-1], req_q, 1'b0};
            m   <= {req_sgn & req_m[WIDTH-1], req_m};
            cnt <= '0;
        end else if ((state == RUN) && !flush) begin
            a   <= {s_sum[WIDTH], s_sum[WIDTH:1]};
            q   <= {s_sum[0], q[WIDTH+1:1]};
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed and random checks of booth_seq_ctrl against an arithmetic product model.
module tb_booth_seq_ctrl;

    localparam int W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [W-1:0]    req_q = '0;
    logic [W-1:0]    req_m = '0;
    logic            req_sgn = 1'b0;
    logic            flush = 1'b0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [2*W-1:0]  resp_z;
    logic            busy;

    int tests = 0;
    int fails = 0;

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_q      (req_q),
        .req_m      (req_m),
        .req_sgn    (req_sgn),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_z     (resp_z),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample/drive point is 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [W-1:0] qv, input logic [W-1:0] mv, input logic s);
        longint x, y, p;
        x = s ? longint'($signed(qv)) : longint'({48'b0, qv});
        y = s ? longint'($signed(mv)) : longint'({48'b0, mv});
        p = x * y;
        return p[31:0];
    endfunction

    // Present a request for one edge, then scramble the operand inputs.
    task automatic start(input logic [W-1:0] qv, input logic [W-1:0] mv, input logic s);
        req_q = qv; req_m = mv; req_sgn = s; req_valid = 1'b1;
        check("ready_before_accept", req_ready, 1);
        step();
        req_valid = 1'b0;
        req_q = W'($urandom); req_m = W'($urandom); req_sgn = ~s;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic retire();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("idle_after_retire_valid", resp_valid, 0);
        check("idle_after_retire_ready", req_ready, 1);
    endtask

    task automatic mul(input string tag, input logic [W-1:0] qv, input logic [W-1:0] mv,
                       input logic s, input logic [31:0] exp);
        int lat;
        start(qv, mv, s);
        wait_done(lat);
        check({tag, "_latency"}, 64'(lat), 64'(W + 1));
        check(tag, resp_z, exp);
        retire();
    endtask

    initial begin
        int lat;
        logic [W-1:0] rq, rm;
        logic rs;
        logic [31:0] held;

        #2;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_z", resp_z, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        #10 rst_n = 1'b1;
        step();
        check("post_rst_ready", req_ready, 1);

        mul("signed_3x-5",    16'h0003, 16'hFFFB, 1'b1, 32'hFFFFFFF1);
        mul("unsigned_ffff",  16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        mul("signed_ffff",    16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
        mul("signed_min_min", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
        mul("signed_min_max", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
        mul("zero_q",         16'h0000, 16'hABCD, 1'b1, 32'h0);
        mul("zero_m",         16'hFEDC, 16'h0000, 1'b0, 32'h0);

        for (int i = 0; i < 24; i++) begin
            rq = W'($urandom); rm = W'($urandom); rs = 1'($urandom);
            mul("random", rq, rm, rs, model(rq, rm, rs));
        end

        // Backpressure: product must hold while the consumer stalls.
        start(16'h1234, 16'h5678, 1'b0);
        wait_done(lat);
        held = resp_z;
        check("bp_value", held, model(16'h1234, 16'h5678, 1'b0));
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_stable", resp_z, held);
            check("bp_ready_low", req_ready, 0);
            check("bp_valid_high", resp_valid, 1);
        end
        retire();
        start(16'h0002, 16'h0003, 1'b0);
        wait_done(lat);
        check("bp_next_value", resp_z, 32'h6);
        retire();

        // Flush mid-run after eight steps.
        start(16'h00FF, 16'h00FF, 1'b0);
        for (int i = 0; i < 7; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_run_busy", busy, 0);
        check("flush_run_valid", resp_valid, 0);
        check("flush_run_ready", req_ready, 1);

        // Flush while holding a result.
        start(16'h0010, 16'h0010, 1'b0);
        wait_done(lat);
        check("flush_done_pre", resp_valid, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_done_valid", resp_valid, 0);
        check("flush_done_z", resp_z, 0);
        check("flush_done_busy", busy, 0);

        // Flush coincident with a request: not accepted.
        req_q = 16'h0005; req_m = 16'h0005; req_sgn = 1'b0;
        req_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; req_valid = 1'b0;
        check("flush_req_busy", busy, 0);
        check("flush_req_ready", req_ready, 1);
        step();
        check("flush_req_still_idle", busy, 0);

        // Asynchronous reset between edges while running.
        start(16'h7777, 16'h3333, 1'b1);
        for (int i = 0; i < 5; i++) step();
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", resp_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", req_ready, 0);
        check("arst_z", resp_z, 0);
        step();
        #2 rst_n = 1'b1;
        #1;
        check("arst_release_ready", req_ready, 1);
        check("arst_release_busy", busy, 0);
        step();
        mul("post_arst_3x7", 16'h0003, 16'h0007, 1'b0, 32'h00000015);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
